bitcoin_nonce_feeder: RTL
=========================

# bitcoin_nonce_feeder

Upstream sequencer for the single-block SHA-256 core in bitcoin phase two/three. It takes a precomputed midstate, the three header-tail words and a nonce range. For each nonce it builds the padded second header block and runs it through the core, then builds the padded block of the resulting 256-bit digest and runs that through the core. Each double-hash result is returned with its nonce over a valid/ready handshake. The parent instantiates the hash core beside this block and wires `core_*` to it.

## Interface
- NUM_NONCES, default 16: nonces processed per `start`, range 1..2^16.
- clk  in  1: clock, all state on rising edge.
- reset  in  1: asynchronous, active-high; one clock; reset is asynchronous and active-high.
- start  in  1: begin a run; sampled only in IDLE.
- midstate  in  32x8: chaining value after header block 1; captured at start.
- tail  in  32x3: header words 16..18; captured at start.
- nonce_base  in  32: first nonce; captured at start.
- core_start  out  1: one-cycle start pulse to the hash core.
- core_w  out  32x16: message block to the core; registered.
- core_hin  out  32x8: chaining input to the core; registered.
- core_done  in  1: core completion pulse.
- core_hout  in  32x8: core digest; valid while core_done=1.
- res_valid  out  1: result available.
- res_ready  in  1: consumer accepts result.
- res_nonce  out  32: nonce of the current result.
- res_hash  out  32x8: final double-SHA digest, word 0 first.
- busy  out  1: high in any state other than IDLE.
- done  out  1: one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE, START1, WAIT1, START2, WAIT2, OUT, FIN.
- **IDLE**, on start: capture midstate, tail and nonce_base (into nonce), clear count, go to START1.
- **START1**:
  - core_w = {tail[0], tail[1], tail[2], nonce, 32'h80000000, ten 32'h0, 32'h00000280}.
  - core_hin = midstate.
  - core_start=1 for exactly this cycle, then go to WAIT1.
- **WAIT1**, on core_done: latch core_hout into dig1, go to START2.
- **START2**:
  - core_w = {dig1[0..7], 32'h80000000, six 32'h0, 32'h00000100}.
  - core_hin = SHA-256 IV (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19).
  - core_start=1 for one cycle, then go to WAIT2.
- **WAIT2**, on core_done: latch core_hout into res_hash, res_nonce = nonce, res_valid=1, go to OUT.
- **OUT**:
  - Hold res_valid and data stable until res_ready is high on a clock edge. The transfer occurs on that edge; res_ready while res_valid=0 has no effect.
  - On transfer: res_valid=0, nonce += 1 (mod 2^32, FFFFFFFF wraps to 00000000), count += 1.
  - If count reaches NUM_NONCES, go to FIN; else go to START1.
- **FIN**: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- core_done outside WAIT1/WAIT2 is ignored.
- core_w and core_hin stay stable from START1/START2 until the matching core_done.
- Reset: state=IDLE. core_start, res_valid, busy, done = 0. core_w, core_hin, res_nonce, res_hash, internal registers = 0.
- Reset mid-run abandons the run with no done pulse. The core is reset from the same source by the parent.

## Timing
- start on edge 0 → core_start high in cycle 1.
- core_done on edge N → START2 core_start high in cycle N+1.
- Second core_done on edge M → res_valid high in cycle M+1.
- Per-nonce overhead beyond two core latencies: 3 cycles plus handshake wait.
- Transfer on edge T:
  - Not last nonce: next core_start is high in cycle T+1.
  - Last nonce: done is high in cycle T+1 and busy falls in cycle T+2.
- Any core latency ≥1 cycle is tolerated.
- core_done in the same cycle as core_start is not expected; it is ignored because the state is still START*.

## Structure
- Shared package `bitcoin_pkg`: SHA256_IV[8], PAD_WORD (32'h80000000), LEN_640 (32'h280), LEN_256 (32'h100), state enum type.
- No sub-module. Block-word assembly is inline combinational logic on registered sources. The hash core is instantiated by the parent, not inside this block.

## Test plan
Unless noted, benches use a stub core with fixed latency 5 and hout[i] = hin[i] + w[i].
- **Single nonce.** NUM_NONCES=1, nonce_base=0x12345678, midstate all 0, tail={1,2,3}, res_ready=1.
  - First core_w = {1,2,3,12345678,80000000,0…,280}.
  - res_hash[3] = IV[3] + 0x12345678.
  - done pulses once.
- **Nonce wrap.** NUM_NONCES=3, nonce_base=0xFFFFFFFE → res_nonce sequence FFFFFFFE, FFFFFFFF, 00000000, then done.
- **Backpressure.** Hold res_ready=0 for 20 cycles → res_valid, res_nonce and res_hash are stable, and no core_start is issued until acceptance.
- **Ignored events.**
  - start pulsed while in WAIT1 → run unchanged.
  - Spurious core_done in OUT → no state change.
- **Reset mid-run.** Assert reset in WAIT2 → all outputs 0 immediately. A fresh start afterwards produces the correct results from nonce_base.
- **Real core.** Connect the real core and the mainnet block-125552 header, with NUM_NONCES=1 at the winning nonce → res_hash matches the known double SHA-256 result.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// Shared constants and types for the bitcoin double-SHA nonce sequencer.
// Array index 0 is always word 0 of a hash or message block.
package bitcoin_pkg;

  typedef logic [7:0][31:0]  hash_t;
  typedef logic [15:0][31:0] block_t;
  typedef logic [2:0][31:0]  tail_t;

  localparam hash_t SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };
  localparam logic [31:0] PAD_WORD = 32'h80000000;
  localparam logic [31:0] LEN_640  = 32'h00000280;
  localparam logic [31:0] LEN_256  = 32'h00000100;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START1, ST_WAIT1, ST_START2, ST_WAIT2, ST_OUT, ST_FIN
  } state_e;

  // Second header block: 3 tail words, nonce, padding, 640-bit length.
  function automatic block_t make_block1(input tail_t t, input logic [31:0] nonce);
    block_t b;
    b     = '0;
    b[0]  = t[0];
    b[1]  = t[1];
    b[2]  = t[2];
    b[3]  = nonce;
    b[4]  = PAD_WORD;
    b[15] = LEN_640;
    return b;
  endfunction

  // Padded block holding the first-pass digest (256-bit message).
  function automatic block_t make_block2(input hash_t d);
    block_t b;
    b = '0;
    for (int i = 0; i < 8; i++) b[i] = d[i];
    b[8]  = PAD_WORD;
    b[15] = LEN_256;
    return b;
  endfunction

endpackage

// File: rtl/bitcoin_nonce_feeder.sv
// Drives an external single-block SHA-256 core twice per nonce (header, then digest)
// and returns each double-hash with its nonce over a valid/ready port.
module bitcoin_nonce_feeder
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  hash_t        midstate,
  input  tail_t        tail,
  input  logic [31:0]  nonce_base,
  output logic         core_start,
  output block_t       core_w,
  output hash_t        core_hin,
  input  logic         core_done,
  input  hash_t        core_hout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_nonce,
  output hash_t        res_hash,
  output logic         busy,
  output logic         done,
  output state_e       dbg_state
);

  // Result port: a transfer happens on any rising edge where res_valid and
  // res_ready are both high; res_valid/res_nonce/res_hash hold until then.

  localparam logic [16:0] LAST_COUNT = 17'(NUM_NONCES);

  state_e      state_q, state_d;
  hash_t       mid_q, mid_d;
  tail_t       tail_q, tail_d;
  logic [31:0] nonce_q, nonce_d;
  logic [16:0] count_q, count_d;
  hash_t       dig1_q, dig1_d;
  block_t      core_w_q, core_w_d;
  hash_t       core_hin_q, core_hin_d;
  logic        core_start_q, core_start_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_nonce_q, res_nonce_d;
  hash_t       res_hash_q, res_hash_d;
  logic        done_q, done_d;

  always_comb begin
    state_d     = state_q;
    mid_d       = mid_q;
    tail_d      = tail_q;
    nonce_d     = nonce_q;
    count_d     = count_q;
    dig1_d      = dig1_q;
    core_w_d    = core_w_q;
    core_hin_d  = core_hin_q;
    res_valid_d = res_valid_q;
    res_nonce_d = res_nonce_q;
    res_hash_d  = res_hash_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mid_d      = midstate;
          tail_d     = tail;
          nonce_d    = nonce_base;
          count_d    = '0;
          core_w_d   = make_block1(tail, nonce_base);
          core_hin_d = midstate;
          state_d    = ST_START1;
        end
      end
      ST_START1: state_d = ST_WAIT1;
      ST_WAIT1: begin
        if (core_done) begin
          dig1_d     = core_hout;
          core_w_d   = make_block2(dig1_d);
          core_hin_d = SHA256_IV;
          state_d    = ST_START2;
        end
      end
      ST_START2: state_d = ST_WAIT2;
      ST_WAIT2: begin
        if (core_done) begin
          res_hash_d  = core_hout;
          res_nonce_d = nonce_q;
          res_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          nonce_d     = nonce_q + 32'd1;
          count_d     = count_q + 17'd1;
          if (count_d == LAST_COUNT) begin
            state_d = ST_FIN;
          end else begin
            // The block for the next nonce is loaded on the same edge as the transfer.
            core_w_d   = make_block1(tail_q, nonce_d);
            core_hin_d = mid_q;
            state_d    = ST_START1;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    core_start_d = (state_d == ST_START1) || (state_d == ST_START2);
    done_d       = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mid_q        <= '0;
      tail_q       <= '0;
      nonce_q      <= '0;
      count_q      <= '0;
      dig1_q       <= '0;
      core_w_q     <= '0;
      core_hin_q   <= '0;
      core_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_nonce_q  <= '0;
      res_hash_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mid_q        <= mid_d;
      tail_q       <= tail_d;
      nonce_q      <= nonce_d;
      count_q      <= count_d;
      dig1_q       <= dig1_d;
      core_w_q     <= core_w_d;
      core_hin_q   <= core_hin_d;
      core_start_q <= core_start_d;
      res_valid_q  <= res_valid_d;
      res_nonce_q  <= res_nonce_d;
      res_hash_q   <= res_hash_d;
      done_q       <= done_d;
    end
  end

  assign core_start = core_start_q;
  assign core_w     = core_w_q;
  assign core_hin   = core_hin_q;
  assign res_valid  = res_valid_q;
  assign res_nonce  = res_nonce_q;
  assign res_hash   = res_hash_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule
